// File: rtl/mips_pkg.sv
// Shared encodings for the fetch/decode controller: opcodes, functs,
// ALU operation codes, register-write destination codes and FSM states.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] ALUOP_NONE = 5'd0;
  localparam logic [4:0] ALUOP_ADD  = 5'd1;
  localparam logic [4:0] ALUOP_SUB  = 5'd2;
  localparam logic [4:0] ALUOP_AND  = 5'd3;
  localparam logic [4:0] ALUOP_OR   = 5'd4;
  localparam logic [4:0] ALUOP_SLT  = 5'd5;

  localparam logic [1:0] REGW_NONE = 2'b00;
  localparam logic [1:0] REGW_RD   = 2'b01;
  localparam logic [1:0] REGW_RT   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_HLT,
    CLS_ILL
  } inst_cls_e;

  // Word-aligned branch displacement from the 16-bit immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class plus the static
// datapath controls that class implies.
import mips_pkg::*;

module ctrl_decode (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output inst_cls_e  cls_o,
  output logic [4:0] aluop_o,
  output logic       cdataop_o,
  output logic [1:0] regw_o
);

  // Class and static controls; an unknown R funct collapses to illegal.
  always_comb begin
    cls_o     = CLS_ILL;
    aluop_o   = ALUOP_NONE;
    cdataop_o = 1'b0;
    regw_o    = REGW_NONE;
    case (opcode_i)
      OP_R: begin
        cls_o     = CLS_R;
        cdataop_o = 1'b1;
        regw_o    = REGW_RD;
        case (funct_i)
          FN_ADD:  aluop_o = ALUOP_ADD;
          FN_SUB:  aluop_o = ALUOP_SUB;
          FN_AND:  aluop_o = ALUOP_AND;
          FN_OR:   aluop_o = ALUOP_OR;
          FN_SLT:  aluop_o = ALUOP_SLT;
          default: begin
            cls_o     = CLS_ILL;
            cdataop_o = 1'b0;
            regw_o    = REGW_NONE;
          end
        endcase
      end
      OP_ADDI: begin
        cls_o   = CLS_ADDI;
        aluop_o = ALUOP_ADD;
        regw_o  = REGW_RT;
      end
      OP_LW: begin
        cls_o   = CLS_LW;
        aluop_o = ALUOP_ADD;
        regw_o  = REGW_RT;
      end
      OP_SW: begin
        cls_o   = CLS_SW;
        aluop_o = ALUOP_ADD;
      end
      OP_BEQ: begin
        cls_o     = CLS_BEQ;
        aluop_o   = ALUOP_SUB;
        cdataop_o = 1'b1;
      end
      OP_J:    cls_o = CLS_J;
      OP_HLT:  cls_o = CLS_HLT;
      default: cls_o = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Multi-cycle fetch/decode controller: owns the PC, the instruction
// register and the sequencing FSM, and drives the datapath control bus.
//
// state  | meaning
// FETCH  | latch instruction word into IR
// DECODE | classify IR; HLT or undefined opcode goes to HALT
// EXEC   | ALU operation; branches and jumps resolve here
// MEM    | data memory access (LW read, SW write)
// WB     | register file write
// HALT   | absorbing stop state, left only by reset
import mips_pkg::*;

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] id,
  input  logic        zf,
  output logic [31:0] instr_addr,
  output logic        immop,
  output logic [4:0]  aluop,
  output logic        memw,
  output logic [1:0]  regw,
  output logic        cdataop,
  output logic        cdatast,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q;
  logic [31:0] ir_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc4;
  logic        halted_q;
  logic        illegal_q;

  inst_cls_e   dec_cls;
  logic [4:0]  dec_aluop;
  logic        dec_cdataop;
  logic [1:0]  dec_regw;

  ctrl_decode u_dec (
    .opcode_i  (ir_q[31:26]),
    .funct_i   (ir_q[5:0]),
    .cls_o     (dec_cls),
    .aluop_o   (dec_aluop),
    .cdataop_o (dec_cdataop),
    .regw_o    (dec_regw)
  );

  assign pc4 = pc_q + 32'd4;

  // Next PC, consumed only on the transition back into FETCH.
  always_comb begin
    pc_d = pc4;
    case (dec_cls)
      CLS_BEQ: pc_d = zf ? (pc4 + branch_offset(ir_q[15:0])) : pc4;
      CLS_J:   pc_d = {pc4[31:28], ir_q[25:0], 2'b00};
      default: pc_d = pc4;
    endcase
  end

  // Sequencing FSM with IR, PC and the sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (en) begin
      case (state_q)
        S_FETCH: begin
          ir_q    <= id;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (dec_cls == CLS_ILL) begin
            illegal_q <= 1'b1;
            halted_q  <= 1'b1;
            state_q   <= S_HALT;
          end else if (dec_cls == CLS_HLT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (dec_cls)
            CLS_LW, CLS_SW:  state_q <= S_MEM;
            CLS_R, CLS_ADDI: state_q <= S_WB;
            default: begin
              pc_q    <= pc_d;
              state_q <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (dec_cls == CLS_LW) begin
            state_q <= S_WB;
          end else begin
            pc_q    <= pc_d;
            state_q <= S_FETCH;
          end
        end
        S_WB: begin
          pc_q    <= pc_d;
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Control bus from the current state; write strobes also need en and no reset.
  always_comb begin
    immop   = 1'b0;
    aluop   = ALUOP_NONE;
    cdataop = 1'b0;
    memw    = 1'b0;
    regw    = REGW_NONE;
    cdatast = 1'b1;
    if (!rst) begin
      if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        aluop   = dec_aluop;
        cdataop = dec_cdataop;
      end
      if (en) begin
        memw = (state_q == S_MEM) && (dec_cls == CLS_SW);
        regw = (state_q == S_WB) ? dec_regw : REGW_NONE;
      end
      cdatast = !((state_q == S_WB) && (dec_cls == CLS_LW));
    end
  end

  assign instr_addr = pc_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule
